// File: rtl/eight_bit_half_adder.sv
// Unsigned 8-bit ripple-carry adder, no carry-in, for the systolic-array PEs.
// Combinational sum/carry plus an optional one-cycle registered copy with valid flag.
module eight_bit_half_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       in_vld,
    output logic [7:0] out,
    output logic       cout,
    output logic [7:0] sum_q,
    output logic       cout_q,
    output logic       vld_q
);

    logic [7:0] w_sum;
    logic [7:0] w_carry;

    // Bit 0 has no carry-in, so it is a plain half adder.
    assign w_sum[0]   = a[0] ^ b[0];
    assign w_carry[0] = a[0] & b[0];

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_full_adder
            logic w_prop;
            assign w_prop        = a[gi] ^ b[gi];
            assign w_sum[gi]     = w_prop ^ w_carry[gi-1];
            assign w_carry[gi]   = (a[gi] & b[gi]) | (w_carry[gi-1] & w_prop);
        end
    endgenerate

    assign out  = w_sum;
    assign cout = w_carry[7];

    logic [7:0] r_sum_q;
    logic       r_cout_q;
    logic       r_vld_q;

    // Reset wins over in_vld; without in_vld the data holds but valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum_q  <= 8'd0;
            r_cout_q <= 1'b0;
            r_vld_q  <= 1'b0;
        end else if (in_vld) begin
            r_sum_q  <= w_sum;
            r_cout_q <= w_carry[7];
            r_vld_q  <= 1'b1;
        end else begin
            r_vld_q  <= 1'b0;
        end
    end

    assign sum_q  = r_sum_q;
    assign cout_q = r_cout_q;
    assign vld_q  = r_vld_q;

endmodule

// File: tb/tb_eight_bit_half_adder.sv
// Directed and exhaustive checks of eight_bit_half_adder: combinational sum/carry
// and the registered stage (capture, hold, reset priority, streaming, release).
module tb_eight_bit_half_adder;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_vld;
    logic [7:0] out;
    logic       cout;
    logic [7:0] sum_q;
    logic       cout_q;
    logic       vld_q;

    int checks;
    int errors;

    eight_bit_half_adder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .in_vld (in_vld),
        .out    (out),
        .cout   (cout),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .vld_q  (vld_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge so outputs are sampled clear of it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [7:0] s, input logic c, input logic v);
        check({tag, ".sum_q"},  {1'b0, sum_q},  {1'b0, s});
        check({tag, ".cout_q"}, {8'd0, cout_q}, {8'd0, c});
        check({tag, ".vld_q"},  {8'd0, vld_q},  {8'd0, v});
        $display("%s: sum_q=%0d cout_q=%0d vld_q=%0d", tag, sum_q, cout_q, vld_q);
    endtask

    // Hand-computed wrap boundaries: a, b, out, cout
    logic [7:0] wrap_a    [5] = '{8'd255, 8'd200, 8'd255, 8'd0, 8'd127};
    logic [7:0] wrap_b    [5] = '{8'd1,   8'd100, 8'd255, 8'd0, 8'd128};
    logic [7:0] wrap_out  [5] = '{8'd0,   8'd44,  8'd254, 8'd0, 8'd255};
    logic       wrap_cout [5] = '{1'b1,   1'b1,   1'b1,   1'b0, 1'b0};

    // Streaming vectors with hand-computed registered results
    logic [7:0] st_a    [4] = '{8'd1, 8'd3, 8'd250, 8'd128};
    logic [7:0] st_b    [4] = '{8'd2, 8'd4, 8'd10,  8'd128};
    logic [7:0] st_sum  [4] = '{8'd3, 8'd7, 8'd4,   8'd0};
    logic       st_cout [4] = '{1'b0, 1'b0, 1'b1,   1'b1};

    initial begin
        int sweep_err_start;
        logic [8:0] total;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        in_vld = 1'b0;
        a      = 8'd0;
        b      = 8'd0;

        tick();
        tick();
        check_regs("reset", 8'd0, 1'b0, 1'b0);

        // Combinational path must stay correct while reset is held.
        a = 8'd255; b = 8'd1; #1;
        check("in_reset.out",  {1'b0, out},  9'd0);
        check("in_reset.cout", {8'd0, cout}, 9'd1);
        $display("in_reset: a=255 b=1 out=%0d cout=%0d", out, cout);

        rst_n = 1'b1;
        sweep_err_start = errors;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                a = i[7:0];
                b = j[7:0];
                #1;
                total = 9'(i + j);
                check("sweep.out",  {1'b0, out},  {1'b0, total[7:0]});
                check("sweep.cout", {8'd0, cout}, {8'd0, total[8]});
            end
        end
        $display("sweep: 65536 vectors, %0d errors", errors - sweep_err_start);

        for (int k = 0; k < 5; k++) begin
            a = wrap_a[k];
            b = wrap_b[k];
            #1;
            check("wrap.out",  {1'b0, out},  {1'b0, wrap_out[k]});
            check("wrap.cout", {8'd0, cout}, {8'd0, wrap_cout[k]});
            $display("wrap: a=%0d b=%0d out=%0d cout=%0d", a, b, out, cout);
        end

        // Registers were untouched by the sweep since in_vld stayed low.
        tick();
        check_regs("post_sweep", 8'd0, 1'b0, 1'b0);

        in_vld = 1'b1; a = 8'd10; b = 8'd20;
        tick();
        check_regs("capture", 8'd30, 1'b0, 1'b1);

        in_vld = 1'b0; a = 8'd1; b = 8'd1;
        #1;
        check("hold.out", {1'b0, out}, 9'd2);
        tick();
        check_regs("hold", 8'd30, 1'b0, 1'b0);

        rst_n = 1'b0; in_vld = 1'b1; a = 8'd255; b = 8'd1;
        #1;
        check("rst_prio.out",  {1'b0, out},  9'd0);
        check("rst_prio.cout", {8'd0, cout}, 9'd1);
        tick();
        check_regs("rst_prio", 8'd0, 1'b0, 1'b0);

        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_vld = 1'b1;
            a = st_a[k];
            b = st_b[k];
            tick();
            check_regs("stream", st_sum[k], st_cout[k], 1'b1);
        end

        // Data and carry hold when in_vld drops, valid does not.
        in_vld = 1'b0; a = 8'd9; b = 8'd9;
        tick();
        check_regs("stream_hold", 8'd0, 1'b1, 1'b0);

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check_regs("rel_in_reset", 8'd0, 1'b0, 1'b0);
        rst_n = 1'b1; in_vld = 1'b0; a = 8'd5; b = 8'd6;
        tick();
        check_regs("rel_idle1", 8'd0, 1'b0, 1'b0);
        tick();
        check_regs("rel_idle2", 8'd0, 1'b0, 1'b0);
        in_vld = 1'b1;
        tick();
        check_regs("rel_capture", 8'd11, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
